// File: rtl/countdown_timer_if.sv
// Host-side handshake bundle for countdown_timer.
// The host drives load/load_val/en/stop through the master modport.
// The timer returns cnt/tc/busy through the slave modport.
interface countdown_timer_if #(
  parameter int unsigned WIDTH = 8
);

  // Host -> timer controls
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             stop;

  // Timer -> host status, all registered inside the timer
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             busy;

  modport master (
    output load,
    output load_val,
    output en,
    output stop,
    input  cnt,
    input  tc,
    input  busy
  );

  modport slave (
    input  load,
    input  load_val,
    input  en,
    input  stop,
    output cnt,
    output tc,
    output busy
  );

endinterface : countdown_timer_if

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle terminal-count pulse.
// A load starts a count, each enabled cycle in RUN decrements it, and
// reaching the end of the count raises tc for exactly one cycle.
// Build option: define COUNTDOWN_AUTO_RELOAD_EN for periodic mode, where
// expiry reloads the last loaded value and keeps running. Left undefined,
// the block is one-shot and returns to IDLE at expiry.
// Edge priority: rst > load > stop > decrement.
module countdown_timer #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  countdown_timer_if.slave   bus
);

  localparam int unsigned CW = WIDTH;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] reload_val_q;
  logic [CW-1:0] reload_val_d;
  logic          tc_q;
  logic          tc_d;
  logic          busy_q;
  logic          busy_d;

  // Decoded per-cycle conditions shared by the next-state and output logic
  logic load_c;
  logic stop_c;
  logic load_nonzero_c;
  logic step_c;
  logic expire_c;
  logic dec_c;

  // Qualify inputs in priority order so that only one action applies per edge
  always_comb begin
    load_c         = 1'b0;
    stop_c         = 1'b0;
    load_nonzero_c = 1'b0;
    step_c         = 1'b0;
    expire_c       = 1'b0;
    dec_c          = 1'b0;

    load_c         = bus.load;
    load_nonzero_c = (bus.load_val != CNT_ZERO);
    stop_c         = !bus.load && bus.stop;
    step_c         = !bus.load && !bus.stop && (state_q == RUN) && bus.en;
    // A zero count in RUN is unreachable, but is treated as a hold so the
    // counter can never underflow to all-ones.
    expire_c       = step_c && (cnt_q == CNT_ONE);
    dec_c          = step_c && (cnt_q > CNT_ONE);
  end

  // State and output registers; synchronous reset clears everything,
  // including a tc pulse that would otherwise appear after this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_ZERO;
      reload_val_q <= CNT_ZERO;
      tc_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reload_val_q <= reload_val_d;
      tc_q         <= tc_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state: load picks RUN/IDLE by start value, stop forces IDLE,
  // expiry ends the run unless periodic mode is built in
  always_comb begin
    state_d = state_q;

    if (load_c) begin
      state_d = load_nonzero_c ? RUN : IDLE;
    end else if (stop_c) begin
      state_d = IDLE;
    end else if (expire_c) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      state_d = RUN;
`else
      state_d = IDLE;
`endif
    end
  end

  // Next output values: count, reload register, tc pulse and busy flag
  always_comb begin
    cnt_d        = cnt_q;
    reload_val_d = reload_val_q;
    tc_d         = 1'b0;
    busy_d       = 1'b0;

    if (load_c) begin
      // A load never produces tc, even when it lands on an expiry edge
      cnt_d        = bus.load_val;
      reload_val_d = bus.load_val;
    end else if (stop_c) begin
      // Abort keeps the current count visible for the host
      cnt_d = cnt_q;
    end else if (expire_c) begin
      tc_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      cnt_d = reload_val_q;
`else
      cnt_d = CNT_ZERO;
`endif
    end else if (dec_c) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    // busy mirrors the registered state, so it drops with the tc edge
    busy_d = (state_d == RUN);
  end

  // Registered values out to the host
  assign bus.cnt  = cnt_q;
  assign bus.tc   = tc_q;
  assign bus.busy = busy_q;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: the driver applies one vector per
// cycle and queues the expected registered outputs; a monitor pops and
// compares on the falling edge.
module tb_countdown_timer;

  localparam int unsigned W = 8;

  typedef struct {
    string        name;
    logic [W-1:0] cnt;
    logic         tc;
    logic         busy;
  } exp_t;

  logic clk;
  logic rst;

  countdown_timer_if #(.WIDTH(W)) bus ();

  countdown_timer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   n_tests;
  int   n_failed;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: every registered output update is checked against the queue head
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests = n_tests + 1;
      if (bus.cnt !== e.cnt || bus.tc !== e.tc || bus.busy !== e.busy) begin
        n_failed = n_failed + 1;
        $display("FAIL %s: got cnt=%0d tc=%b busy=%b, want cnt=%0d tc=%b busy=%b",
                 e.name, bus.cnt, bus.tc, bus.busy, e.cnt, e.tc, e.busy);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic apply(input logic r, input logic l, input logic [W-1:0] lv,
                       input logic e, input logic s,
                       input logic [W-1:0] ec, input logic et, input logic eb,
                       input string nm);
    exp_t x;
    rst          = r;
    bus.load     = l;
    bus.load_val = lv;
    bus.en       = e;
    bus.stop     = s;
    @(posedge clk);
    #1;
    x.name = nm;
    x.cnt  = ec;
    x.tc   = et;
    x.busy = eb;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  initial begin
    int budget;
    n_tests      = 0;
    n_failed     = 0;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.en       = 1'b0;
    bus.stop     = 1'b0;
    @(negedge clk);

    // Reset overrides a concurrent load
    apply(1, 1, 8'h55, 0, 0, 8'd0, 0, 0, "reset0");
    apply(1, 1, 8'h55, 0, 0, 8'd0, 0, 0, "reset1");

    // Load zero: never runs, never signals
    apply(0, 1, 8'd0, 1, 0, 8'd0, 0, 0, "load0");
    for (int i = 0; i < 3; i++) apply(0, 0, 8'd0, 1, 0, 8'd0, 0, 0, "load0_en");

    // Priority: load beats expiry
    apply(0, 1, 8'd2, 0, 0, 8'd2, 0, 1, "pri_load2");
    apply(0, 0, 8'd0, 1, 0, 8'd1, 0, 1, "pri_at1");
    apply(0, 1, 8'd4, 1, 0, 8'd4, 0, 1, "pri_load_wins");
    apply(0, 0, 8'd0, 1, 0, 8'd3, 0, 1, "pri_dec3");
    apply(0, 0, 8'd0, 1, 0, 8'd2, 0, 1, "pri_dec2");
    apply(0, 0, 8'd0, 1, 0, 8'd1, 0, 1, "pri_dec1");
    // Priority: stop beats expiry and holds the count
    apply(0, 0, 8'd0, 1, 1, 8'd1, 0, 0, "pri_stop_wins");
    apply(0, 0, 8'd0, 1, 0, 8'd1, 0, 0, "idle_ignores_en");

    // Reset mid-count clears everything
    apply(0, 1, 8'd2, 0, 0, 8'd2, 0, 1, "rst_load2");
    apply(0, 0, 8'd0, 1, 0, 8'd1, 0, 1, "rst_dec1");
    apply(1, 0, 8'd0, 1, 0, 8'd0, 0, 0, "rst_midcount");

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Periodic: load 3, tc every third enabled cycle, cnt never 0
    apply(0, 1, 8'd3, 0, 0, 8'd3, 0, 1, "per_load3");
    for (int i = 1; i <= 12; i++) begin
      logic [W-1:0] c;
      c = W'(3 - (i % 3));
      apply(0, 0, 8'd0, 1, 0, c, (i % 3) == 0, 1, "per_cycle");
    end
    // Reload of 1 expires on every enabled cycle
    apply(0, 1, 8'd1, 0, 0, 8'd1, 0, 1, "per_load1");
    for (int i = 0; i < 3; i++) apply(0, 0, 8'd0, 1, 0, 8'd1, 1, 1, "per_every");
    apply(0, 0, 8'd0, 0, 1, 8'd1, 0, 0, "per_stop");
`else
    // One-shot: load 5 -> 5,4,3,2,1,0 with tc and busy drop together
    apply(0, 1, 8'd5, 1, 0, 8'd5, 0, 1, "os_load5");
    apply(0, 0, 8'd0, 1, 0, 8'd4, 0, 1, "os_4");
    apply(0, 0, 8'd0, 1, 0, 8'd3, 0, 1, "os_3");
    apply(0, 0, 8'd0, 1, 0, 8'd2, 0, 1, "os_2");
    apply(0, 0, 8'd0, 1, 0, 8'd1, 0, 1, "os_1");
    apply(0, 0, 8'd0, 1, 0, 8'd0, 1, 0, "os_expire");
    apply(0, 0, 8'd0, 1, 0, 8'd0, 0, 0, "os_hold0a");
    apply(0, 0, 8'd0, 1, 0, 8'd0, 0, 0, "os_hold0b");

    // Gating: load 3, en = 1,0,0,1,1 -> 2,2,2,1,0
    apply(0, 1, 8'd3, 0, 0, 8'd3, 0, 1, "gate_load3");
    apply(0, 0, 8'd0, 1, 0, 8'd2, 0, 1, "gate_e1");
    apply(0, 0, 8'd0, 0, 0, 8'd2, 0, 1, "gate_e0a");
    apply(0, 0, 8'd0, 0, 0, 8'd2, 0, 1, "gate_e0b");
    apply(0, 0, 8'd0, 1, 0, 8'd1, 0, 1, "gate_e1b");
    apply(0, 0, 8'd0, 1, 0, 8'd0, 1, 0, "gate_expire");
`endif

    // Full-scale start value: 255 enabled cycles to tc, no wrap
    apply(0, 1, 8'hFF, 0, 0, 8'hFF, 0, 1, "ff_load");
    for (int i = 1; i < 255; i++)
      apply(0, 0, 8'd0, 1, 0, W'(255 - i), 0, 1, "ff_count");
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    apply(0, 0, 8'd0, 1, 0, 8'hFF, 1, 1, "ff_expire");
`else
    apply(0, 0, 8'd0, 1, 0, 8'd0, 1, 0, "ff_expire");
    apply(0, 0, 8'd0, 1, 0, 8'd0, 0, 0, "ff_nowrap");
`endif

    // Drain the scoreboard with a bounded wait
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_tests  = n_tests + 1;
      n_failed = n_failed + 1;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule : tb_countdown_timer

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with terminal-count signalling; it is the decrementing counterpart of the team's free-running up-counter. A host loads a start value, and the block counts down one step per enabled clock. It pulses `tc` when the count expires, then either stops or reloads. Downstream logic uses it for timeouts, delays and periodic ticks.

## Interface
- `WIDTH`, default 8: width of the count and the load value, ≥ 2.
- `clk`  in  1  — single clock; all logic rises on `posedge clk`.
- `rst`  in  1  — reset is synchronous and active-high.
- `load`  in  1  — one-cycle request to load `load_val` and start counting.
- `load_val`  in  WIDTH  — start value; sampled only when `load`=1.
- `en`  in  1  — count enable; the count decrements only when `en`=1 in RUN.
- `stop`  in  1  — abort; returns to IDLE and holds `cnt`.
- `cnt`  out  WIDTH  — current count, registered.
- `tc`  out  1  — terminal-count pulse, registered, one cycle wide.
- `busy`  out  1  — 1 while in RUN, registered.

## Operation
- State: `IDLE`, `RUN`. Internal register `reload_val[WIDTH-1:0]`.
- Reset (rst=1 at an edge): state=IDLE, `cnt`=0, `reload_val`=0, `tc`=0, `busy`=0. Reset overrides every other input.
- Input priority per edge: `rst` > `load` > `stop` > decrement.
- `load`=1, in any state:
  - `cnt`←`load_val` and `reload_val`←`load_val`.
  - If `load_val`≠0, state←RUN. If `load_val`=0, state←IDLE and no `tc`.
  - `tc`=0 in that cycle. A `load` in RUN restarts the count.
- `stop`=1 with `load`=0: state←IDLE, `cnt` holds, `tc`=0.
- IDLE, no `load`: `cnt` holds and `en` is ignored.
- RUN, `en`=0: `cnt` holds.
- RUN, `en`=1, `cnt`>1: `cnt`←`cnt`−1.
- RUN, `en`=1, `cnt`=1 (expiry): `tc`←1 for exactly one cycle. The rest of the behaviour depends on the configuration.
- Arithmetic: unsigned, modulo 2^WIDTH. `cnt` never decrements below 0 and never wraps to all-ones.

## Timing
- Load latency: `load` sampled at edge k → `cnt`=`load_val` and `busy`=1 are visible after edge k.
- Expiry: a start value of N with `en` held high gives `tc` after the Nth enabled edge following the load.
- The `tc` high cycle coincides with `cnt` showing its post-expiry value: 0, or `reload_val` in reload mode.
- `busy` falls in the same cycle that `tc` rises when the block stops at expiry.
- `load` and expiry on the same edge: `load` wins and `tc` stays 0.
- `stop` and expiry on the same edge: `stop` wins, `cnt` stays 1, `tc` stays 0.
- `rst` asserted mid-count: all outputs return to reset values after that edge, including an in-flight `tc`.

## Configuration
- Macro `COUNTDOWN_AUTO_RELOAD_EN`.
- Not defined (one-shot):
  - At expiry, `cnt`←0, state←IDLE, `busy`←0, `tc` pulses.
  - Counting resumes only on a new `load`.
- Defined (periodic):
  - At expiry, `cnt`←`reload_val`, state stays RUN, `busy` stays 1, `tc` pulses.
  - With `en` held high, `tc` repeats every `reload_val` cycles.
  - `cnt` never reads 0 while in RUN.
  - `reload_val`=1 gives `tc` on every enabled cycle.
- `stop` and `load` behave identically in both builds.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `load`=1 and `load_val`=8'h55 → `cnt`=0, `tc`=0, `busy`=0.
- One-shot: load 5 with `en`=1 →
  - `cnt` reads 5,4,3,2,1,0 on successive cycles.
  - `tc`=1 only in the cycle `cnt`=0.
  - `busy` falls in that same cycle.
  - Further `en` leaves `cnt`=0.
- Gating: load 3, then drive `en` as 1,0,0,1,1 → `cnt` reads 2,2,2,1,0, with a single `tc` on the last cycle.
- Priority: in RUN at `cnt`=1, assert `load`=1 with `load_val`=4 and `en`=1 → `cnt`=4 and `tc`=0. Repeat with `stop`=1 in place of `load` → `cnt`=1, `busy`=0, `tc`=0.
- Edge values:
  - Load 0 → `busy` stays 0 and `tc` never asserts.
  - Load 8'hFF → exactly 255 enabled cycles to `tc`, with no wrap.
- With `COUNTDOWN_AUTO_RELOAD_EN`: load 3, hold `en`=1 for 12 cycles → `tc` pulses every 3rd cycle (4 pulses), `busy` stays 1, and `cnt` cycles 3,2,1,3,… and never shows 0.
